mem_arbiter: RTL and testbench

- Shares the single-port prime/work table memory (13-bit address, 9-bit data, 1-bit write enable) between two requesters.
  - Port 0: the prime-table writer / sieve stage.
  - Port 1: the Pollard exponentiation stage.
- Round-robin arbitration, one access per cycle, fully pipelined.
- Read data is returned to the originating port with a fixed latency.
- Optional lock lets one port hold the memory for read-modify-write sequences.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared single-port table memory.
// It has an optional per-port lock and returns read data in order after a fixed latency.
module mem_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int DEPTH = MEM_LATENCY + 1;

  logic              last_gnt_reg;
  logic              lock_held_reg;
  logic              lock_port_reg;
  logic              elig0;
  logic              elig1;
  logic              xfer;
  logic              sel;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [DEPTH-1:0]  tag_rd_reg;
  logic [DEPTH-1:0]  tag_port_reg;

  // A port is shut out whenever the other port owns the lock, even if the owner is idle.
  assign elig0 = req0 && !rst && !(lock_held_reg && lock_port_reg);
  assign elig1 = req1 && !rst && !(lock_held_reg && !lock_port_reg);
  assign gnt0  = elig0 && !(elig1 && !last_gnt_reg);
  assign gnt1  = elig1 && !(elig0 && last_gnt_reg);
  assign xfer  = gnt0 | gnt1;
  assign sel   = gnt1;

  assign sel_we   = sel ? we1   : we0;
  assign sel_lock = sel ? lock1 : lock0;
  assign sel_addr = sel ? addr1 : addr0;
  assign sel_din  = sel ? din1  : din0;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      last_gnt_reg  <= 1'b1;
      lock_held_reg <= 1'b0;
      lock_port_reg <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
    end else if (xfer) begin
      last_gnt_reg <= sel;
      mem_we       <= sel_we;
      mem_addr     <= sel_addr;
      mem_din      <= sel_din;
      if (sel_lock) begin
        lock_held_reg <= 1'b1;
        lock_port_reg <= sel;
      end else if (lock_held_reg && (lock_port_reg == sel)) begin
        lock_held_reg <= 1'b0;
      end
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Tag stage MEM_LATENCY lines up with mem_dout for the access issued DEPTH edges earlier.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      tag_rd_reg   <= '0;
      tag_port_reg <= '0;
    end else begin
      tag_rd_reg   <= {tag_rd_reg[DEPTH-2:0], xfer & ~sel_we};
      tag_port_reg <= {tag_port_reg[DEPTH-2:0], sel};
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag_rd_reg[MEM_LATENCY] && !tag_port_reg[MEM_LATENCY];
      rvalid1 <= tag_rd_reg[MEM_LATENCY] && tag_port_reg[MEM_LATENCY];
      if (tag_rd_reg[MEM_LATENCY] && !tag_port_reg[MEM_LATENCY]) begin
        rdata0 <= mem_dout;
      end
      if (tag_rd_reg[MEM_LATENCY] && tag_port_reg[MEM_LATENCY]) begin
        rdata1 <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter.
// A write-first memory and a transaction-level reference model are used for checking.
module tb_mem_arbiter;
  localparam int AW  = 13;
  localparam int DW  = 9;
  localparam int LAT = 1;

  typedef struct packed {
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } rq_t;

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW-1:0] mem_addr;

  always #5 clka = ~clka;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clka(clka), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Write-first single-port memory with one cycle of read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clka) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem_we ? mem_din : mem[mem_addr];
  end

  // Reference model: memory contents in issue order plus outstanding reads with due times.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  rd_t           pend[$];
  int            owner, last, cyc;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_rd0, e_rd1;
  int            vectors = 0;
  int            errs = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1;
    e_we = 1'b0; e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    pend.delete();
  endtask

  // Entered and left just after a rising edge; gnt is checked at the falling edge.
  task automatic step(input rq_t p0, input rq_t p1, output bit g0, output bit g1);
    bit   e0, e1, rv0, rv1;
    rq_t  w;
    int   p;
    rd_t  r;
    {req0, we0, lock0, addr0, din0} = p0;
    {req1, we1, lock1, addr1, din1} = p1;
    #4;
    e0 = p0.req && (owner != 1);
    e1 = p1.req && (owner != 0);
    g0 = e0 && !(e1 && last == 0);
    g1 = e1 && !(e0 && last == 1);
    chk("gnt0", {15'd0, gnt0}, {15'd0, g0});
    chk("gnt1", {15'd0, gnt1}, {15'd0, g1});
    @(posedge clka);
    cyc++;
    if (g0 || g1) begin
      p = g1 ? 1 : 0;
      w = g1 ? p1 : p0;
      last = p;
      if (w.lock) owner = p;
      else if (owner == p) owner = -1;
      e_we = w.we; e_addr = w.addr; e_din = w.din;
      if (w.we) shadow[w.addr] = w.din;
      else pend.push_back('{cyc + LAT + 1, p, shadow[w.addr]});
    end else begin
      e_we = 1'b0;
    end
    rv0 = 1'b0; rv1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.port == 0) begin rv0 = 1'b1; e_rd0 = r.data; end
      else begin rv1 = 1'b1; e_rd1 = r.data; end
    end
    #1;
    chk("mem_we", {15'd0, mem_we}, {15'd0, e_we});
    chk("mem_addr", {3'd0, mem_addr}, {3'd0, e_addr});
    chk("mem_din", {7'd0, mem_din}, {7'd0, e_din});
    chk("rvalid0", {15'd0, rvalid0}, {15'd0, rv0});
    chk("rvalid1", {15'd0, rvalid1}, {15'd0, rv1});
    chk("rdata0", {7'd0, rdata0}, {7'd0, e_rd0});
    chk("rdata1", {7'd0, rdata1}, {7'd0, e_rd1});
    $display("cyc %0d req=%b%b gnt=%b%b mem_we=%b addr=%h rv=%b%b rd0=%h rd1=%h",
             cyc, p0.req, p1.req, gnt0, gnt1, mem_we, mem_addr, rvalid0, rvalid1, rdata0, rdata1);
  endtask

  function automatic rq_t mk(input bit rq, input bit w, input bit lk, input int a, input int d);
    rq_t t;
    t.req = rq; t.we = w; t.lock = lk; t.addr = AW'(a); t.din = DW'(d);
    return t;
  endfunction

  initial begin
    rq_t idle, c0, c1;
    bit  g0, g1;
    idle = mk(0, 0, 0, 0, 0);
    cyc = 0;
    model_reset();

    // Reset state, with both requests raised to confirm grants are held off.
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    chk("rst_gnt0", {15'd0, gnt0}, 16'd0);
    chk("rst_gnt1", {15'd0, gnt1}, 16'd0);
    chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("rst_mem_addr", {3'd0, mem_addr}, 16'd0);
    chk("rst_rvalid0", {15'd0, rvalid0}, 16'd0);
    chk("rst_rdata1", {7'd0, rdata1}, 16'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b0;

    // Write 23 to 0x0445, three idle cycles, read it back on port 0.
    step(mk(1, 1, 0, 'h445, 23), idle, g0, g1);
    repeat (3) step(idle, idle, g0, g1);
    step(mk(1, 0, 0, 'h445, 0), idle, g0, g1);
    repeat (3) step(idle, idle, g0, g1);

    // Seed the addresses used by the tie test and the random phase.
    step(mk(1, 1, 0, 'h010, 'h0a5), idle, g0, g1);
    step(mk(1, 1, 0, 'h020, 'h15a), idle, g0, g1);
    for (int a = 'h100; a < 'h110; a++) step(mk(1, 1, 0, a, $urandom), idle, g0, g1);

    // Both ports hold reads: grants and returned data alternate.
    repeat (4) step(mk(1, 0, 0, 'h010, 0), mk(1, 0, 0, 'h020, 0), g0, g1);
    repeat (3) step(idle, idle, g0, g1);

    // Port 1 locks, idles while port 0 waits, then unlocks.
    step(idle, mk(1, 0, 1, 'h020, 0), g0, g1);
    repeat (3) step(mk(1, 0, 0, 'h010, 0), mk(0, 0, 1, 0, 0), g0, g1);
    step(mk(1, 0, 0, 'h010, 0), mk(1, 0, 0, 'h020, 0), g0, g1);
    step(mk(1, 0, 0, 'h010, 0), idle, g0, g1);
    repeat (3) step(idle, idle, g0, g1);

    // Port 1 reads 0x0445 with din=78 on the bus: data stays 23.
    step(idle, mk(1, 0, 0, 'h445, 78), g0, g1);
    step(mk(1, 0, 0, 'h445, 0), idle, g0, g1);
    repeat (3) step(idle, idle, g0, g1);

    // A read in flight is discarded by a one-cycle reset pulse.
    step(mk(1, 0, 0, 'h445, 0), idle, g0, g1);
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("midrst_gnt0", {15'd0, gnt0}, 16'd0);
    chk("midrst_mem_addr", {3'd0, mem_addr}, 16'd0);
    @(posedge clka);
    cyc++;
    #1;
    chk("midrst_rvalid0", {15'd0, rvalid0}, 16'd0);
    rst = 1'b0;
    model_reset();
    step(mk(1, 0, 0, 'h100, 0), mk(1, 0, 0, 'h101, 0), g0, g1);
    repeat (3) step(idle, idle, g0, g1);

    // Randomized traffic; a request stays stable until the model predicts its grant.
    c0 = idle; c1 = idle;
    for (int i = 0; i < 400; i++) begin
      if (!c0.req || g0)
        c0 = mk($urandom_range(2, 0) != 0, $urandom_range(1, 0), $urandom_range(3, 0) == 0,
                'h100 + $urandom_range(15, 0), $urandom);
      if (!c1.req || g1)
        c1 = mk($urandom_range(2, 0) != 0, $urandom_range(1, 0), $urandom_range(3, 0) == 0,
                'h100 + $urandom_range(15, 0), $urandom);
      step(c0, c1, g0, g1);
    end
    repeat (4) step(idle, idle, g0, g1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
